alu_uart_interface: RTL and testbench



---
 rtl/alu_uart_interface.sv | 145 ++++++++++++++
 tb/tb_alu_uart_interface.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects operand A, operand B and an opcode from the
// UART receiver, presents them as registered ALU inputs, and passes the
// settled ALU result to the UART transmitter.
// Optional build macro: ALU_IF_TIMEOUT_EN adds an inter-byte timeout in
// WAIT_B / WAIT_OP that returns the sequencer to WAIT_A.
//
// Handshakes: rx_done is a one-cycle strobe qualifying rx_data. It is
// consumed in the three operand states; in any busy state the byte is
// dropped and overrun is set. tx_start is a one-cycle request issued in
// SEND, and tx_data is stable from that cycle until the next result.
// tx_done is a one-cycle completion strobe and is only honoured in WAIT_TX.
module alu_uart_interface #(
  parameter int A_W            = 7,
  parameter int OP_W           = 6,
  parameter int RES_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic [RES_W-1:0] alu_result,
  input  logic             tx_done,
  output logic [A_W-1:0]   alu_a,
  output logic [A_W-1:0]   alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state, state_next;
  logic   load_a, load_b, load_op, load_res, drop;
  logic   timeout;

  // Upper rx bits and, in the default build, the timeout length are unused.
  logic unused_bits;
  assign unused_bits = ^{rx_data, alu_result, (TIMEOUT_CYCLES == 0)};

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Idle-cycle counter for the two mid-sequence states; restarts on any byte or state change.
  always_ff @(posedge clk) begin
    if (reset || (state_next != state) || rx_done ||
        !((state == WAIT_B) || (state == WAIT_OP)))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !rx_done;
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_next;
  end

  // Next-state, load strobes and handshake outputs.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    drop       = 1'b0;
    tx_start   = 1'b0;
    busy       = 1'b0;
    case (state)
      WAIT_A: begin
        if (rx_done) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (timeout) begin
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done) begin
          load_op    = 1'b1;
          state_next = EXEC;
        end else if (timeout) begin
          state_next = WAIT_A;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        drop       = rx_done;
        load_res   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy       = 1'b1;
        drop       = rx_done;
        tx_start   = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        drop = rx_done;
        if (tx_done) state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase
  end

  // Operand, opcode, result and overrun registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
      overrun <= 1'b0;
    end else begin
      if (load_a)   alu_a   <= rx_data[A_W-1:0];
      if (load_b)   alu_b   <= rx_data[A_W-1:0];
      if (load_op)  alu_op  <= rx_data[OP_W-1:0];
      if (load_res) tx_data <= 8'(alu_result);
      if (drop)     overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a result scoreboard.
module tb_alu_uart_interface;

  localparam int A_W   = 7;
  localparam int OP_W  = 6;
  localparam int RES_W = 8;
  localparam int EW    = 2 * A_W + OP_W + 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_done = 1'b0;
  logic [RES_W-1:0] alu_result = '0;
  logic             tx_done = 1'b0;
  logic [A_W-1:0]   alu_a;
  logic [A_W-1:0]   alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             busy;
  logic             overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cap = 0;
  logic prev_start = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  alu_uart_interface #(
    .A_W(A_W), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .alu_result(alu_result), .tx_done(tx_done), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .overrun(overrun)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx strobe; returns the cycle number of the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    last_cap = cyc;
    rx_done = 1'b0;
  endtask

  // Full three-byte sequence; expected outputs are pushed to the scoreboard.
  task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] res, input logic [A_W-1:0] ea,
                          input logic [A_W-1:0] eb, input logic [OP_W-1:0] eop);
    alu_result = res;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    exp_q.push_back({ea, eb, eop, res});
    exp_cyc_q.push_back(last_cap + 1);
  endtask

  // Advance from EXEC through SEND into WAIT_TX.
  task automatic to_wait_tx();
    step();
    step();
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  // Monitor: every tx_start is matched against the next expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        if (prev_start) check("tx_start_single", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          check("tx_result", 32'({alu_a, alu_b, alu_op, tx_data}), 32'(exp_q.pop_front()));
          check("tx_start_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end
      prev_start <= tx_start;
    end else begin
      prev_start <= 1'b0;
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    step();
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    step();

    // Basic sequence: 7, 2, op 0x20, result 0x09.
    send_seq(8'h07, 8'h02, 8'h20, 8'h09, 7'd7, 7'd2, 6'h20);
    check("exec_alu_op", 32'(alu_op), 32'h20);
    check("exec_busy", 32'(busy), 1);
    to_wait_tx();
    check("wait_tx_busy", 32'(busy), 1);
    check("wait_tx_data", 32'(tx_data), 32'h09);
    pulse_tx_done();
    check("idle_busy", 32'(busy), 0);
    check("no_overrun", 32'(overrun), 0);

    // tx_done outside WAIT_TX is ignored.
    pulse_tx_done();
    check("stray_tx_done_busy", 32'(busy), 0);

    // Truncation of upper rx bits.
    send_seq(8'hFF, 8'h81, 8'hC2, 8'h5A, 7'h7F, 7'h01, 6'h02);
    to_wait_tx();
    send_byte(8'h55);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_alu_a", 32'(alu_a), 32'h7F);
    check("ovr_alu_b", 32'(alu_b), 32'h01);
    check("ovr_alu_op", 32'(alu_op), 32'h02);
    check("ovr_busy", 32'(busy), 1);
    pulse_tx_done();
    check("ovr_idle_busy", 32'(busy), 0);
    check("ovr_sticky", 32'(overrun), 1);

    // tx_done and rx_done together in WAIT_TX.
    send_seq(8'h03, 8'h04, 8'h05, 8'h33, 7'd3, 7'd4, 6'd5);
    to_wait_tx();
    rx_data = 8'h11;
    rx_done = 1'b1;
    tx_done = 1'b1;
    step();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("both_busy", 32'(busy), 0);
    check("both_overrun", 32'(overrun), 1);
    check("both_alu_a", 32'(alu_a), 3);
    send_seq(8'h0A, 8'h0B, 8'h0C, 8'h77, 7'h0A, 7'h0B, 6'h0C);
    to_wait_tx();
    pulse_tx_done();

    // Reset in WAIT_B.
    send_byte(8'h12);
    check("pre_rst_alu_a", 32'(alu_a), 32'h12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_alu_a", 32'(alu_a), 0);
    check("mid_rst_alu_b", 32'(alu_b), 0);
    check("mid_rst_alu_op", 32'(alu_op), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    send_seq(8'h01, 8'h02, 8'h03, 8'h44, 7'd1, 7'd2, 6'd3);
    to_wait_tx();
    pulse_tx_done();

`ifdef ALU_IF_TIMEOUT_EN
    // Inter-byte timeout: a lone byte is abandoned after 16 idle cycles.
    send_byte(8'h15);
    for (int i = 0; i < 16; i++) step();
    send_seq(8'h2A, 8'h06, 8'h01, 8'h5C, 7'h2A, 7'h06, 6'h01);
    to_wait_tx();
    pulse_tx_done();
`endif

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
